// File: rtl/fifo_frame_writer.sv
// rtl/fifo_frame_writer.sv - framed FIFO write-side producer (header, payload, XOR trailer); optional stats via FRAME_WRITER_STATS_EN
module fifo_frame_writer #(
    parameter int DATA    = 8,
    parameter int MAX_LEN = 255,
    parameter int CNT_W   = 16,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DATA-1:0]  s_data,
    input  logic             s_last,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [DATA-1:0]  fifo_din,
    output logic             busy,
    output logic             frame_trunc,
`ifdef FRAME_WRITER_STATS_EN
    output logic [31:0]      stall_cnt,
    output logic [LW-1:0]    max_len_seen,
`endif
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DATA-1:0] seq_q, seq_d;
    logic [DATA-1:0] chk_q, chk_d;
    logic [LW-1:0]   len_q, len_d;
    logic            pend_q, pend_d;
    logic            trunc_d;
    logic            frame_done;
    logic            load;
    logic [DATA-1:0] load_data;
    logic            slot_free;
    logic            beat;
    logic [LW:0]     len_inc;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign slot_free = !fifo_wr_en || !fifo_full;
    assign s_ready   = (state_q == PAYLOAD) && slot_free;
    assign beat      = s_valid && s_ready;
    assign busy      = (state_q != IDLE) || fifo_wr_en;
    assign len_inc   = {1'b0, len_q} + 1'b1;

    // Next-state logic: decides what word (if any) enters the output register.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        chk_d      = chk_q;
        len_d      = len_q;
        pend_d     = pend_q;
        trunc_d    = 1'b0;
        frame_done = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        case (state_q)
            IDLE: begin
                // Header goes out before any payload is consumed.
                if (s_valid && slot_free) begin
                    load      = 1'b1;
                    load_data = seq_q;
                    chk_d     = '0;
                    len_d     = '0;
                    pend_d    = 1'b0;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    load      = 1'b1;
                    load_data = s_data;
                    chk_d     = chk_q ^ s_data;
                    len_d     = len_inc[LW-1:0];
                    if (s_last || (len_inc == (LW+1)'(MAX_LEN))) begin
                        pend_d  = !s_last;
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = chk_q;
                    seq_d      = seq_q + 1'b1;
                    trunc_d    = pend_q;
                    frame_done = 1'b1;
                    pend_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and per-frame bookkeeping registers.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            pend_q      <= 1'b0;
            frame_trunc <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            len_q       <= len_d;
            pend_q      <= pend_d;
            frame_trunc <= trunc_d;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Output stage: hold the word while the FIFO is full, otherwise take the new load.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else if (slot_free) begin
            fifo_wr_en <= load;
            if (load) begin
                fifo_din <= load_data;
            end
        end
    end

`ifdef FRAME_WRITER_STATS_EN
    // Stall cycles saturate; longest payload is sampled as each trailer is loaded.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            stall_cnt    <= '0;
            max_len_seen <= '0;
        end else begin
            if (fifo_wr_en && fifo_full && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (frame_done && (len_q > max_len_seen)) begin
                max_len_seen <= len_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb/tb_fifo_frame_writer.sv - scoreboard bench for fifo_frame_writer
module tb_fifo_frame_writer;

    localparam int DATA    = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             wr_clk = 1'b0;
    logic             wr_rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DATA-1:0]  s_data = '0;
    logic             s_last = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [DATA-1:0]  fifo_din;
    logic             busy;
    logic             frame_trunc;
    logic [CNT_W-1:0] frame_cnt;
`ifdef FRAME_WRITER_STATS_EN
    logic [31:0]      stall_cnt;
    logic [LW-1:0]    max_len_seen;
`endif

    fifo_frame_writer #(.DATA(DATA), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .wr_clk      (wr_clk),
        .wr_rst_n    (wr_rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .busy        (busy),
        .frame_trunc (frame_trunc),
`ifdef FRAME_WRITER_STATS_EN
        .stall_cnt   (stall_cnt),
        .max_len_seen(max_len_seen),
`endif
        .frame_cnt   (frame_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    logic [DATA-1:0] exp_q[$];
    int              cons_cyc[$];
    int              cyc = 0;
    int              ready_cycles = 0;
    int              trunc_seen = 0;
    bit              ignore = 1'b0;

    // reference model state
    int              model_seq = 0;
    int              model_frames = 0;
    int              model_trunc = 0;

    bit              full_mode = 1'b0;
    bit              full_force = 1'b0;
    bit              gaps = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Backpressure generator
    initial begin
        forever begin
            @(posedge wr_clk);
            #2;
            fifo_full = full_mode ? ($urandom_range(0, 2) == 0) : full_force;
        end
    end

    // Monitor: every consumed FIFO word is checked against the scoreboard
    initial begin
        forever begin
            @(negedge wr_clk);
            cyc++;
            if (wr_rst_n) begin
                if (s_ready) ready_cycles++;
                if (frame_trunc) trunc_seen++;
                if (fifo_wr_en && !fifo_full) begin
                    cons_cyc.push_back(cyc);
                    if (!ignore) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL word: got %0h expected none", fifo_din);
                        end else begin
                            logic [DATA-1:0] e;
                            e = exp_q.pop_front();
                            if (fifo_din !== e) begin
                                errors++;
                                $display("FAIL word: got %0h expected %0h", fifo_din, e);
                            end
                        end
                    end
                end
            end
        end
    end

    // Frame model: split into MAX_LEN chunks, each with header and XOR trailer
    task automatic push_frame(input logic [DATA-1:0] b[$]);
        int idx = 0;
        int n = b.size();
        while (idx < n) begin
            int chunk;
            logic [DATA-1:0] x;
            chunk = (n - idx > MAX_LEN) ? MAX_LEN : n - idx;
            x = '0;
            exp_q.push_back(DATA'(model_seq));
            for (int i = 0; i < chunk; i++) begin
                exp_q.push_back(b[idx + i]);
                x = x ^ b[idx + i];
            end
            exp_q.push_back(x);
            model_seq = (model_seq + 1) % (1 << DATA);
            model_frames++;
            if (idx + chunk < n) model_trunc++;
            idx += chunk;
        end
    endtask

    task automatic send_byte(input logic [DATA-1:0] d, input logic l);
        bit hs = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 500 && !hs; t++) begin
            @(negedge wr_clk);
            hs = s_ready;
            @(posedge wr_clk);
            #1;
        end
        if (!hs) check("handshake_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data = DATA'($urandom);
            s_last = 1'($urandom);
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DATA-1:0] b[$]);
        push_frame(b);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], i == b.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(posedge wr_clk);
            #1;
            t++;
        end
        check("drain_timeout", (t < 2000) ? 1 : 0, 1);
    endtask

    task automatic check_consecutive(input string name, input int n);
        int sz = cons_cyc.size();
        int ok = 1;
        if (sz < n) ok = 0;
        else
            for (int i = sz - n + 1; i < sz; i++)
                if (cons_cyc[i] != cons_cyc[i-1] + 1) ok = 0;
        check(name, ok, 1);
    endtask

    initial begin
        logic [DATA-1:0] fr[$];
        int rc_base, tr_base;

        // reset state
        repeat (3) @(posedge wr_clk);
        #1;
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_trunc", frame_trunc, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        wr_rst_n = 1'b1;
        idle(2);

        // single three-byte frame, no backpressure
        rc_base = ready_cycles;
        tr_base = trunc_seen;
        fr = '{8'h11, 8'h22, 8'h44};
        send_frame(fr);
        drain();
        check_consecutive("t1_consecutive", 5);
        check("t1_ready_cycles", ready_cycles - rc_base, 3);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_trunc", trunc_seen - tr_base, 0);

        // two back-to-back one-byte frames
        fr = '{8'hA5};
        send_frame(fr);
        fr = '{8'h5A};
        send_frame(fr);
        drain();
        check_consecutive("t2_consecutive", 6);
        check("t2_frame_cnt", frame_cnt, 3);

        // five-cycle stall while 0x22 is held
        fr = '{8'h11, 8'h22, 8'h44};
        push_frame(fr);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        s_data = 8'h44;
        s_last = 1'b1;
        full_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            check("t3_hold_din", fifo_din, 8'h22);
            check("t3_hold_wr_en", fifo_wr_en, 1);
            check("t3_ready_low", s_ready, 0);
            @(posedge wr_clk);
            #1;
        end
        full_force = 1'b0;
        send_byte(8'h44, 1'b1);
        s_valid = 1'b0;
        drain();
        check("t3_frame_cnt", frame_cnt, 4);
`ifdef FRAME_WRITER_STATS_EN
        check("t3_stall_cnt", stall_cnt, 5);
        check("t3_max_len", max_len_seen, 3);
`endif

        // truncation at MAX_LEN
        tr_base = trunc_seen;
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(fr);
        drain();
        check("t4_trunc", trunc_seen - tr_base, 1);
        check("t4_frame_cnt", frame_cnt, 6);
`ifdef FRAME_WRITER_STATS_EN
        check("t4_max_len", max_len_seen, MAX_LEN);
`endif

        // reset in the middle of a frame
        ignore = 1'b1;
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        wr_rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t5_wr_en", fifo_wr_en, 0);
        check("t5_din", fifo_din, 0);
        check("t5_s_ready", s_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_trunc", frame_trunc, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        model_seq = 0;
        model_frames = 0;
        model_trunc = 0;
        exp_q.delete();
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
        ignore = 1'b0;
        idle(2);
        tr_base = trunc_seen;
        fr = '{8'h33};
        send_frame(fr);
        drain();
        check("t5_frame_cnt_after", frame_cnt, 1);

        // randomized traffic with backpressure and gaps
        full_mode = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 10);
            fr.delete();
            for (int i = 0; i < n; i++) fr.push_back(DATA'($urandom));
            send_frame(fr);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        drain();
        check("rand_frame_cnt", frame_cnt, CNT_W'(model_frames));
        check("rand_trunc", trunc_seen - tr_base, model_trunc);

        // enough one-byte frames to wrap the header sequence
        gaps = 1'b0;
        for (int f = 0; f < 257; f++) begin
            fr = '{DATA'($urandom)};
            send_frame(fr);
        end
        full_mode = 1'b0;
        drain();
        check("wrap_frame_cnt", frame_cnt, CNT_W'(model_frames));
        check("wrap_exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
